// File: rtl/cache_flush_sequencer.sv
// cache_flush_sequencer: clears every tag valid bit after reset and on each CP15 flush, stalling the core, and registers a per-access cacheability decode.
// Ports:
//   i_clk, i_rst            clock and synchronous active-high reset
//   i_cache_flush           single-cycle flush request from CP15
//   i_cache_enable          cache on/off
//   i_cacheable_area        one bit per 2MB region of the low 64MB
//   i_address(_valid)       core access address and its qualifier
//   o_stall                 high while the sequencer owns the tag RAM
//   o_tag_wenable/waddr     per-way write enable and line index being cleared
//   o_tag_wdata_valid       valid bit written (always 0)
//   o_flush_done            one-cycle pulse at the end of a sweep
//   o_cacheable             registered cacheability of the last valid address
//   o_flush_count           completed sweeps, saturating (only with CACHE_FLUSH_STATS_EN)
module cache_flush_sequencer #(
    parameter int WAYS   = 4,
    parameter int LINES  = 256,
    parameter int LINE_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cache_flush,
    input  logic              i_cache_enable,
    input  logic [31:0]       i_cacheable_area,
    input  logic [31:0]       i_address,
    input  logic              i_address_valid,
    output logic              o_stall,
    output logic [WAYS-1:0]   o_tag_wenable,
    output logic [LINE_W-1:0] o_tag_waddr,
    output logic              o_tag_wdata_valid,
    output logic              o_flush_done,
    output logic              o_cacheable
`ifdef CACHE_FLUSH_STATS_EN
    ,
    output logic [15:0]       o_flush_count
`endif
);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
    state_t            state, state_nx;
    logic [LINE_W-1:0] cnt, cnt_nx;
    logic              cache_q;
    logic              decode;
    logic              unused_addr;
    assign unused_addr = ^i_address[20:0];
    assign decode = i_cache_enable & (i_address[31:26] == 6'd0) & i_cacheable_area[i_address[25:21]];
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= SWEEP;
            cnt     <= '0;
            cache_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            // the decode register is cleared while the tag RAM is busy so no stale hit survives a sweep
            cache_q <= (state != IDLE) ? 1'b0 : i_address_valid ? decode : cache_q;
        end
    end
    // a flush in any state restarts the sweep from line 0; the last line wraps cnt to 0 naturally
    always_comb begin
        state_nx          = (state == SWEEP) ? ((!i_cache_flush && cnt == LINE_W'(LINES - 1)) ? DONE : SWEEP)
                                             : (i_cache_flush ? SWEEP : IDLE);
        cnt_nx            = (state == SWEEP && !i_cache_flush) ? cnt + LINE_W'(1) : '0;
        o_stall           = i_rst | (state != IDLE);
        o_tag_wenable     = (!i_rst && state == SWEEP) ? {WAYS{1'b1}} : '0;
        o_tag_waddr       = cnt;
        o_tag_wdata_valid = 1'b0;
        o_flush_done      = !i_rst && state == DONE;
        o_cacheable       = !i_rst && state == IDLE && cache_q;
    end
`ifdef CACHE_FLUSH_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_flush_count <= '0;
        else if (o_flush_done && o_flush_count != 16'hFFFF)
            o_flush_count <= o_flush_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_cache_flush_sequencer.sv
// tb_cache_flush_sequencer: scoreboard bench for tag sweeps, done pulses, stall and cacheability decode.
module tb_cache_flush_sequencer;
    logic        i_clk = 0;
    logic        i_rst = 1;
    logic        i_cache_flush = 0;
    logic        i_cache_enable = 0;
    logic [31:0] i_cacheable_area = 0;
    logic [31:0] i_address = 0;
    logic        i_address_valid = 0;
    logic        o_stall;
    logic [3:0]  o_tag_wenable;
    logic [7:0]  o_tag_waddr;
    logic        o_tag_wdata_valid;
    logic        o_flush_done;
    logic        o_cacheable;
`ifdef CACHE_FLUSH_STATS_EN
    logic [15:0] o_flush_count;
`endif
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int addr_q[$];
    int done_q[$];
    bit cache_q[$];

    cache_flush_sequencer dut (
`ifdef CACHE_FLUSH_STATS_EN
        .o_flush_count(o_flush_count),
`endif
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_cache_flush(i_cache_flush),
        .i_cache_enable(i_cache_enable),
        .i_cacheable_area(i_cacheable_area),
        .i_address(i_address),
        .i_address_valid(i_address_valid),
        .o_stall(o_stall),
        .o_tag_wenable(o_tag_wenable),
        .o_tag_waddr(o_tag_waddr),
        .o_tag_wdata_valid(o_tag_wdata_valid),
        .o_flush_done(o_flush_done),
        .o_cacheable(o_cacheable)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // advance to the stable point just after the edge that starts cycle k
    task automatic go(input int k);
        repeat (k - cyc) @(posedge i_clk);
        #1;
    endtask

    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) addr_q.push_back(i);
    endtask

    always @(negedge i_clk) begin
        chk("wdata_valid", {31'd0, o_tag_wdata_valid}, 0);
        if (o_tag_wenable != 0) begin
            chk("wen", {28'd0, o_tag_wenable}, 32'hF);
            if (addr_q.size() == 0) chk("write_extra", {24'd0, o_tag_waddr}, 32'hFFFF_FFFF);
            else chk("waddr", {24'd0, o_tag_waddr}, addr_q.pop_front());
        end
        if (o_flush_done) begin
            if (done_q.size() == 0) chk("done_extra", cyc, 0);
            else chk("done_cyc", cyc, done_q.pop_front());
        end
    end

    typedef struct { bit en; logic [31:0] area; logic [31:0] addr; bit exp; } cvec_t;
    cvec_t cv[6] = '{
        '{1, 32'h0000_0002, 32'h0020_0000, 1},
        '{1, 32'h0000_0002, 32'h0040_0000, 0},
        '{1, 32'h0000_0002, 32'h0420_0000, 0},
        '{0, 32'h0000_0002, 32'h0020_0000, 0},
        '{1, 32'h0000_0002, 32'h001F_FFFF, 0},
        '{1, 32'h8000_0000, 32'h03FF_FFFF, 1}
    };

    initial begin
        int base, t, x;
        go(2);
        chk("rst_stall", {31'd0, o_stall}, 1);
        chk("rst_wen", {28'd0, o_tag_wenable}, 0);
        chk("rst_done", {31'd0, o_flush_done}, 0);
        chk("rst_cacheable", {31'd0, o_cacheable}, 0);
        go(3);
        i_rst = 0;
        base = cyc;
        push_sweep(256);
        done_q.push_back(base + 256);
        chk("init_stall0", {31'd0, o_stall}, 1);
        go(base + 256);
        chk("init_stall_done", {31'd0, o_stall}, 1);
        go(base + 257);
        chk("init_stall_idle", {31'd0, o_stall}, 0);
        chk("init_writes", addr_q.size(), 0);

        go(base + 400);
        i_cache_flush = 1;
        chk("flush_no_comb_stall", {31'd0, o_stall}, 0);
        push_sweep(256);
        done_q.push_back(base + 657);
        go(base + 401);
        i_cache_flush = 0;
        chk("flush_stall_start", {31'd0, o_stall}, 1);
        go(base + 657);
        chk("flush_stall_end", {31'd0, o_stall}, 1);
        go(base + 658);
        chk("flush_stall_idle", {31'd0, o_stall}, 0);
        chk("flush_writes", addr_q.size(), 0);

        go(base + 800);
        i_cache_flush = 1;
        push_sweep(101);
        go(base + 801);
        i_cache_flush = 0;
        go(base + 901);
        i_cache_flush = 1;
        push_sweep(256);
        done_q.push_back(base + 1158);
        go(base + 902);
        i_cache_flush = 0;
        go(base + 1160);
        chk("restart_writes", addr_q.size(), 0);
        chk("restart_done", done_q.size(), 0);
`ifdef CACHE_FLUSH_STATS_EN
        chk("stats_three", {16'd0, o_flush_count}, 3);
`endif

        t = base + 1200;
        foreach (cv[i]) begin
            go(t);
            i_cache_enable = cv[i].en;
            i_cacheable_area = cv[i].area;
            i_address = cv[i].addr;
            i_address_valid = 1;
            cache_q.push_back(cv[i].exp);
            t++;
            go(t);
            i_address_valid = 0;
            chk($sformatf("cacheable_%0d", i), {31'd0, o_cacheable}, {31'd0, cache_q.pop_front()});
        end
        i_address = 32'h0420_0000;
        go(t + 2);
        chk("cacheable_hold", {31'd0, o_cacheable}, 1);

        t = base + 1300;
        go(t);
        i_cache_flush = 1;
        push_sweep(256);
        done_q.push_back(t + 257);
        go(t + 1);
        i_cache_flush = 0;
        chk("cacheable_sweep_forced", {31'd0, o_cacheable}, 0);
        go(t + 10);
        i_address = 32'h03FF_FFFF;
        i_address_valid = 1;
        go(t + 11);
        i_address_valid = 0;
        chk("cacheable_sweep_addr", {31'd0, o_cacheable}, 0);
        go(t + 260);

        x = base + 1700;
        go(x);
        i_cache_flush = 1;
        push_sweep(50);
        go(x + 1);
        i_cache_flush = 0;
        go(x + 51);
        i_rst = 1;
        i_cache_flush = 1;
        chk("midrst_stall", {31'd0, o_stall}, 1);
        go(x + 52);
        i_cache_flush = 0;
        chk("midrst_wen", {28'd0, o_tag_wenable}, 0);
        chk("midrst_done", {31'd0, o_flush_done}, 0);
        go(x + 54);
        i_rst = 0;
        push_sweep(256);
        done_q.push_back(x + 54 + 256);
        go(x + 54 + 258);
        chk("midrst_stall_idle", {31'd0, o_stall}, 0);
        chk("final_writes", addr_q.size(), 0);
        chk("final_done", done_q.size(), 0);
`ifdef CACHE_FLUSH_STATS_EN
        chk("stats_after_rst", {16'd0, o_flush_count}, 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
